// File: rtl/mem_responder.sv
// Bus-side memory responder: single-beat reads/writes to a byte array with a
// fixed number of wait states and an error completion for unmapped addresses.
module mem_responder #(
   parameter int unsigned ADDR_W      = 5,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned DEPTH       = 24,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              ack,
   output logic              err,
   output logic [DATA_W-1:0] rdata
);

   localparam logic [3:0]      WaitCnt = 4'(WAIT_STATES);
   localparam logic [ADDR_W:0] DepthW  = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                wr_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                err_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                hold_en;
   logic                commit;

   logic [DATA_W-1:0]   mem [DEPTH];

   // With zero wait states the commit happens on the accepting edge, before the
   // holding registers are loaded, so the live bus values are used instead.
   logic                cmt_wr;
   logic [ADDR_W-1:0]   cmt_addr;
   logic [DATA_W-1:0]   cmt_wdata;
   logic                mapped;

   assign cmt_wr    = (state_q == StIdle) ? wr    : wr_q;
   assign cmt_addr  = (state_q == StIdle) ? addr  : addr_q;
   assign cmt_wdata = (state_q == StIdle) ? wdata : wdata_q;
   assign mapped    = ({1'b0, cmt_addr} < DepthW);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_en = 1'b0;
      commit  = 1'b0;
      case (state_q)
         StIdle: begin
            if (req) begin
               hold_en = 1'b1;
               cnt_d   = WaitCnt;
               if (WAIT_STATES == 0) begin
                  state_d = StResp;
                  commit  = 1'b1;
               end else begin
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = StResp;
               commit  = 1'b1;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (hold_en) begin
            wr_q    <= wr;
            addr_q  <= addr;
            wdata_q <= wdata;
         end
         if (commit) begin
            err_q <= ~mapped;
            if (!cmt_wr) begin
               rdata_q <= mapped ? mem[cmt_addr] : '0;
            end
         end
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (commit && cmt_wr && mapped) begin
         mem[cmt_addr] <= cmt_wdata;
      end
   end

   assign busy  = (state_q != StIdle);
   assign ack   = (state_q == StResp);
   assign err   = err_q;
   assign rdata = rdata_q;

endmodule
